// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front-end blocks.
//   fft_state_t  : input reorder controller states.
//   bit_reverse  : reverses the low 'width' bits of an index.
//   twiddle_one  : largest positive Q1.(tw-1) value, the real part of W0.
package fft_pkg;

  typedef enum logic [1:0] {
    FILL,
    PRIME,
    DRAIN
  } fft_state_t;

  function automatic int unsigned bit_reverse(input int unsigned idx,
                                              input int unsigned width);
    int unsigned r;
    r = '0;
    for (int unsigned i = 0; i < width; i++) begin
      if (idx[i]) r[width-1-i] = 1'b1;
    end
    return r;
  endfunction

  function automatic int unsigned twiddle_one(input int unsigned tw);
    return (32'd1 << (tw - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fft_bit_reverse.sv
// Combinational index bit-reverser.
//   idx : input index, width bits.
//   rev : idx with its bit order reversed.
module fft_bit_reverse
  import fft_pkg::*;
#(
  parameter int unsigned width = 4
) (
  input  logic [width-1:0] idx,
  output logic [width-1:0] rev
);

  assign rev = width'(bit_reverse(32'(idx), width));

endmodule

// File: rtl/fft_input_reorder.sv
// Collects one frame of fft_size real samples into a bit-reversed sample
// memory, then streams fft_size/2 even/odd pairs with twiddle W0 for the
// radix-2 DIT base butterflies.
//   clk, rst                : clock, synchronous active-high reset.
//   in_sample/in_valid/in_ready          : input sample stream.
//   even_out/odd_out        : pair k = (mem[2k], mem[2k+1]).
//   twiddle_real/imag       : W0 while out_valid, else 0.
//   out_valid/out_ready     : output pair handshake.
//   out_index/out_last      : pair number k, final pair marker.
module fft_input_reorder
  import fft_pkg::*;
#(
  parameter int sample_size  = 32,
  parameter int twiddle_size = 16,
  parameter int fft_size     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [sample_size-1:0]            in_sample,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [sample_size-1:0]            even_out,
  output logic [sample_size-1:0]            odd_out,
  output logic [twiddle_size-1:0]           twiddle_real,
  output logic [twiddle_size-1:0]           twiddle_imag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(fft_size/2)-1:0]     out_index,
  output logic                              out_last
);

  localparam int aw     = $clog2(fft_size);
  localparam int kw     = $clog2(fft_size / 2);
  localparam int last_k = fft_size / 2 - 1;
  localparam logic [twiddle_size-1:0] tw_one = twiddle_size'(twiddle_one(twiddle_size));

  if (fft_size < 4 || (fft_size & (fft_size - 1)) != 0) begin : g_bad_size
    $error("fft_input_reorder: fft_size must be a power of 2 and >= 4");
  end

  logic [sample_size-1:0] mem [fft_size];

  fft_state_t     state, state_nxt;
  logic [aw-1:0]  wcnt;
  logic [aw-1:0]  waddr;
  logic [kw-1:0]  next_k;
  logic [aw-1:0]  ev_addr, od_addr;
  logic           accept, pair_taken, load_pair, last_taken;

  fft_bit_reverse #(.width(aw)) u_wrev (
    .idx (wcnt),
    .rev (waddr)
  );

  assign in_ready     = (state == FILL) && !rst;
  assign accept       = in_valid && in_ready;
  assign pair_taken   = out_valid && out_ready;
  assign load_pair    = (state == PRIME) || ((state == DRAIN) && pair_taken && !out_last);
  assign last_taken   = (state == DRAIN) && pair_taken && out_last;
  assign twiddle_imag = '0;

  // Pair index to present next: 0 when priming, otherwise the successor
  always_comb begin
    next_k = '0;
    if (state == DRAIN) next_k = out_index + kw'(1);
  end

  assign ev_addr = {next_k, 1'b0};
  assign od_addr = {next_k, 1'b1};

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (accept && wcnt == aw'(fft_size - 1)) state_nxt = PRIME;
      PRIME:   state_nxt = DRAIN;
      DRAIN:   if (last_taken) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[waddr] <= in_sample;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      wcnt         <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_index    <= '0;
      even_out     <= '0;
      odd_out      <= '0;
      twiddle_real <= '0;
    end else begin
      state <= state_nxt;
      // wcnt wraps to 0 on the final sample because fft_size is a power of 2
      if (accept) wcnt <= wcnt + aw'(1);
      if (load_pair) begin
        even_out     <= mem[ev_addr];
        odd_out      <= mem[od_addr];
        out_index    <= next_k;
        out_last     <= (next_k == kw'(last_k));
        out_valid    <= 1'b1;
        twiddle_real <= tw_one;
      end else if (last_taken) begin
        even_out     <= '0;
        odd_out      <= '0;
        out_index    <= '0;
        out_last     <= 1'b0;
        out_valid    <= 1'b0;
        twiddle_real <= '0;
      end
    end
  end

endmodule

// File: doc/fft_input_reorder.md
Name: fft_input_reorder

Overview:
Upstream feeder for the 2-point base butterfly stage. It collects one frame of fft_size real audio samples through a valid/ready stream and stores them in bit-reversed address order. It then streams out fft_size/2 even/odd sample pairs, each with the base-case twiddle W0, in the order the radix-2 DIT base butterflies consume them. Its output bus matches the butterfly's even/odd/twiddle inputs one-to-one.

Parameters:
- sample_size, 32: width of one signed real sample.
- twiddle_size, 16: width of the signed Q1.(twiddle_size-1) twiddle components.
- fft_size, 16: frame length. Must be a power of 2 and at least 4; elaboration fails otherwise.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_sample  input  sample_size  signed input sample.
- in_valid  input  1  in_sample is valid.
- in_ready  output  1  block accepts a sample this cycle.
- even_out  output  sample_size  signed even sample, to butterfly even_buffer.
- odd_out  output  sample_size  signed odd sample, to butterfly odd_buffer.
- twiddle_real  output  twiddle_size  W0 real part.
- twiddle_imag  output  twiddle_size  W0 imaginary part.
- out_valid  output  1  pair outputs are valid.
- out_ready  input  1  downstream accepts the pair.
- out_index  output  $clog2(fft_size/2)  pair number k.
- out_last  output  1  asserted with the final pair of a frame.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=FILL, write count=0, pair count=0.
  - out_valid=0, out_last=0, out_index=0, even_out=0, odd_out=0.
  - twiddle outputs are 0.
  - in_ready=0 while rst is high.
  - Sample memory contents are don't-care.
- Reset mid-frame, in any state: the partial frame or undrained pairs are discarded with no further out_valid. The block restarts in FILL.
- States: FILL -> PRIME -> DRAIN -> FILL.
- FILL:
  - in_ready=1 (combinational from state, gated by !rst).
  - Accept a sample on in_valid && in_ready, writing mem[bitrev(wcnt)] <= in_sample, then wcnt++.
  - When sample fft_size-1 is accepted: wcnt wraps to 0 and the next state is PRIME.
  - in_valid low causes no state change and no write.
- PRIME:
  - Exactly one cycle; in_ready=0, out_valid=0.
  - At the closing edge, load the output registers with pair 0, set out_valid=1, and go to DRAIN.
- DRAIN:
  - in_ready=0. in_valid is ignored and no data is lost upstream, because the source must hold it.
  - Pair k presents even_out=mem[2k], odd_out=mem[2k+1], out_index=k, out_last=(k==fft_size/2-1).
  - twiddle_real=2^(twiddle_size-1)-1 and twiddle_imag=0 while out_valid=1; both are 0 otherwise.
  - All outputs are registered and stay stable while out_valid && !out_ready.
  - On out_valid && out_ready with k < last: load pair k+1 at the next edge. This sustains one pair per cycle.
  - On acceptance of the last pair: out_valid=0 and out_last=0 next cycle, and state goes to FILL.
- Latency: the first pair is valid 2 cycles after the edge that accepts the final sample (one PRIME bubble).
- Throughput: fft_size + 1 + fft_size/2 cycles per frame, minimum.
- No arithmetic is performed. Samples pass bit-exact and sign is preserved.
- Because the butterfly runs with zero imaginary inputs, pair (mem[2k], mem[2k+1]) equals (x[j], x[j+fft_size/2]) for j=bitrev-derived. This is correct for stage-0 DIT.

Decomposition:
- Package fft_pkg holds:
  - typedef enum {FILL, PRIME, DRAIN} for the state.
  - function bit_reverse(idx, width).
  - constant TWIDDLE_ONE(twiddle_size) = 2^(twiddle_size-1)-1.
- Sub-module fft_bit_reverse: parameterised, combinational index bit-reverser of width $clog2(fft_size). Reused later by the output reorder stage.
- The sample memory is an inferred register array of fft_size x sample_size.

Test Plan:
- fft_size=8, sample_size=32, twiddle_size=16. Feed 10..17 back-to-back with out_ready=1.
  - Pairs must be (10,14),(12,16),(11,15),(13,17) with out_index 0..3.
  - out_last only on index 3, twiddle_real=32767, twiddle_imag=0.
  - First out_valid appears exactly 2 cycles after sample 17 is accepted.
- Signed data: feed -1, -2^31, 2^31-1, 0, 5, -5, 7, -7.
  - Pairs must be (-1,5),(2^31-1,7),(-2^31,-5),(0,-7), bit-exact.
- Backpressure: hold out_ready=0 for 3 cycles on pair 1, toggle it randomly afterwards.
  - Outputs stay stable while stalled; no pair is skipped or duplicated.
  - in_ready stays 0 throughout DRAIN.
- Input gaps and overrun: insert in_valid=0 gaps during FILL. Keep in_valid=1 during PRIME/DRAIN with the next frame's sample 20.
  - Gaps do not change the count.
  - Sample 20 is not consumed until FILL resumes.
  - Next frame starting at 20 drains as (20,24),(22,26),(21,25),(23,27).
- Reset mid-operation: assert rst for 1 cycle after 5 samples, and again during the DRAIN of pair 2.
  - All outputs read 0 and in_ready=0 during rst.
  - The next full frame drains correctly from index 0, with no stale pairs emitted.
- Parameter sweep with fft_size=4 and 32, using ramp inputs.
  - Pair k must equal (x[bitrev(2k)], x[bitrev(2k+1)]).
  - out_index width is $clog2(fft_size/2).
